// File: rtl/alu.sv
// 16-bit ALU with S/Z/C/V flags and a committed flag register.
// Optional barrel shifter enabled by defining ALU_SHIFT_EN.
module alu #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       S_ALU,
   input  logic [WIDTH-1:0] DATA_A,
   input  logic [WIDTH-1:0] DATA_B,
   input  logic             flag_latch,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic [3:0]       FLAG_OUT,
   output logic             FLAG_WRITE,
   output logic [3:0]       FLAG_Q
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_CMP  = 4'b0101;
   localparam logic [3:0] OP_MOV  = 4'b0110;
   localparam logic [3:0] OP_IDT  = 4'b1100;
   localparam logic [3:0] OP_OUT  = 4'b1101;
`ifdef ALU_SHIFT_EN
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SLR  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
`endif

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic             add_v;
   logic             sub_v;

   logic [WIDTH-1:0] res;
   logic             c_flag;
   logic             v_flag;
   logic             fw;

   logic [3:0]       flag_d;
   logic [3:0]       flag_q;

   // Shared adder/subtractor; bit WIDTH carries out the carry or borrow
   always_comb begin
      sum_w  = {1'b0, DATA_A} + {1'b0, DATA_B};
      diff_w = {1'b0, DATA_A} - {1'b0, DATA_B};
      add_v  = (DATA_A[WIDTH-1] == DATA_B[WIDTH-1])
             & (sum_w[WIDTH-1] ^ DATA_A[WIDTH-1]);
      sub_v  = (DATA_A[WIDTH-1] != DATA_B[WIDTH-1])
             & (diff_w[WIDTH-1] ^ DATA_A[WIDTH-1]);
   end

`ifdef ALU_SHIFT_EN
   logic [3:0]              shamt;
   logic [WIDTH:0]          sll_w;
   logic [WIDTH:0]          srl_w;
   logic signed [WIDTH:0]   sra_s;
   logic [WIDTH:0]          sra_w;
   logic [WIDTH-1:0]        rol_w;

   // Barrel shifter; one spare bit on each side catches the last bit out
   always_comb begin
      shamt = DATA_B[3:0];
      sll_w = {1'b0, DATA_A} << shamt;
      srl_w = {DATA_A, 1'b0} >> shamt;
      sra_s = {DATA_A, 1'b0};
      sra_w = sra_s >>> shamt;
      rol_w = (DATA_A << shamt)
            | (DATA_A >> (5'(WIDTH) - {1'b0, shamt}));
   end
`endif

   // Function decode: result, carry, overflow and flag-write enable
   always_comb begin
      res    = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      fw     = 1'b0;
      unique case (S_ALU)
         OP_ADD: begin
            res    = sum_w[WIDTH-1:0];
            c_flag = sum_w[WIDTH];
            v_flag = add_v;
            fw     = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            res    = diff_w[WIDTH-1:0];
            c_flag = diff_w[WIDTH];
            v_flag = sub_v;
            fw     = 1'b1;
         end
         OP_AND: begin
            res = DATA_A & DATA_B;
            fw  = 1'b1;
         end
         OP_OR: begin
            res = DATA_A | DATA_B;
            fw  = 1'b1;
         end
         OP_XOR: begin
            res = DATA_A ^ DATA_B;
            fw  = 1'b1;
         end
         OP_MOV: begin
            res = DATA_B;
            fw  = 1'b1;
         end
`ifdef ALU_SHIFT_EN
         OP_SLL: begin
            res    = sll_w[WIDTH-1:0];
            c_flag = (shamt != 4'd0) & sll_w[WIDTH];
            fw     = 1'b1;
         end
         OP_SLR: begin
            res = rol_w;
            fw  = 1'b1;
         end
         OP_SRL: begin
            res    = srl_w[WIDTH:1];
            c_flag = (shamt != 4'd0) & srl_w[0];
            fw     = 1'b1;
         end
         OP_SRA: begin
            res    = sra_w[WIDTH:1];
            c_flag = (shamt != 4'd0) & sra_w[0];
            fw     = 1'b1;
         end
`endif
         OP_IDT: res = DATA_B;
         OP_OUT: res = DATA_A;
         default: res = '0;
      endcase
   end

   // Flag vector; S and Z always follow the result
   always_comb begin
      ALU_OUT    = res;
      FLAG_WRITE = fw;
      FLAG_OUT   = {res[WIDTH-1], (res == '0), c_flag, v_flag};
   end

   // Commit new flags only for flag-writing functions
   always_comb begin
      flag_d = flag_q;
      if (flag_latch && fw) flag_d = FLAG_OUT;
   end

   // Committed flag register, cleared asynchronously
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) flag_q <= 4'b0000;
      else          flag_q <= flag_d;
   end

   assign FLAG_Q = flag_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal
// expectations plus a per-cycle compare against a behavioural model.
module tb_alu;

   logic        clock;
   logic        reset_n;
   logic [3:0]  S_ALU;
   logic [15:0] DATA_A;
   logic [15:0] DATA_B;
   logic        flag_latch;
   logic [15:0] ALU_OUT;
   logic [3:0]  FLAG_OUT;
   logic        FLAG_WRITE;
   logic [3:0]  FLAG_Q;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;
   logic [3:0] exp_q;

   alu #(.WIDTH(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .S_ALU      (S_ALU),
      .DATA_A     (DATA_A),
      .DATA_B     (DATA_B),
      .flag_latch (flag_latch),
      .ALU_OUT    (ALU_OUT),
      .FLAG_OUT   (FLAG_OUT),
      .FLAG_WRITE (FLAG_WRITE),
      .FLAG_Q     (FLAG_Q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Behavioural model: integer arithmetic and bit-at-a-time shifts
   function automatic void model(input logic [3:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 output logic [15:0] r,
                                 output logic [3:0] f,
                                 output logic fw);
      int sa, sb, si, d;
      int unsigned ua, ub;
      logic c, v;
      logic [15:0] t;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      d  = int'(b[3:0]);
      c  = 1'b0;
      v  = 1'b0;
      fw = 1'b1;
      r  = 16'h0;
      t  = a;
      case (op)
         4'd0: begin
            r  = 16'(ua + ub);
            c  = (ua + ub) > 65535;
            si = sa + sb;
            v  = (si > 32767) || (si < -32768);
         end
         4'd1, 4'd5: begin
            r  = 16'(ua - ub);
            c  = ua < ub;
            si = sa - sb;
            v  = (si > 32767) || (si < -32768);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd6: r = b;
`ifdef ALU_SHIFT_EN
         4'd8: begin
            for (int i = 0; i < d; i++) begin
               c = t[15];
               t = {t[14:0], 1'b0};
            end
            r = t;
         end
         4'd9: begin
            for (int i = 0; i < d; i++) t = {t[14:0], t[15]};
            r = t;
         end
         4'd10: begin
            for (int i = 0; i < d; i++) begin
               c = t[0];
               t = {1'b0, t[15:1]};
            end
            r = t;
         end
         4'd11: begin
            for (int i = 0; i < d; i++) begin
               c = t[0];
               t = {t[15], t[15:1]};
            end
            r = t;
         end
`endif
         4'd12: begin r = b; fw = 1'b0; end
         4'd13: begin r = a; fw = 1'b0; end
         default: begin r = 16'h0; fw = 1'b0; end
      endcase
      if (!fw) begin
         c = 1'b0;
         v = 1'b0;
      end
      f = {r[15], (r == 16'h0), c, v};
   endfunction

   // Model of the committed flag register
   always @(posedge clock or negedge reset_n) begin
      logic [15:0] mr;
      logic [3:0]  mf;
      logic        mw;
      if (!reset_n) exp_q <= 4'b0000;
      else if (flag_latch) begin
         model(S_ALU, DATA_A, DATA_B, mr, mf, mw);
         if (mw) exp_q <= mf;
      end
   end

   // Per-cycle compare of every output against the model
   always @(negedge clock) begin
      logic [15:0] mr;
      logic [3:0]  mf;
      logic        mw;
      if (chk_en) begin
         model(S_ALU, DATA_A, DATA_B, mr, mf, mw);
         chk("mdl_out", 32'(ALU_OUT), 32'(mr));
         chk("mdl_flag", 32'(FLAG_OUT), 32'(mf));
         chk("mdl_fw", 32'(FLAG_WRITE), 32'(mw));
         chk("mdl_q", 32'(FLAG_Q), 32'(exp_q));
      end
   end

   typedef struct {
      string       nm;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic [3:0]  f;
      logic        fw;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input string nm, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] f,
                       input logic fw);
      vec_t v;
      v.nm = nm; v.op = op; v.a = a; v.b = b;
      v.r = r; v.f = f; v.fw = fw;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic lat);
      @(posedge clock);
      #1;
      S_ALU = op;
      DATA_A = a;
      DATA_B = b;
      flag_latch = lat;
   endtask

   initial begin
      reset_n = 1'b0;
      S_ALU = 4'h0;
      DATA_A = 16'h0;
      DATA_B = 16'h0;
      flag_latch = 1'b0;
      #3;
      chk("reset_q", 32'(FLAG_Q), 32'h0);
      #9;
      reset_n = 1'b1;
      chk_en = 1'b1;

      addv("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1);
      addv("sub_eq",  4'h1, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1);
      addv("cmp_lt",  4'h5, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1);
      addv("and",     4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1);
      addv("or_zero", 4'h3, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1);
      addv("xor",     4'h4, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000, 1);
      addv("add_cy",  4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1);
      addv("sub_ovf", 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1);
      addv("mov0",    4'h6, 16'h1234, 16'h0000, 16'h0000, 4'b0100, 1);
      addv("idt",     4'hC, 16'h5555, 16'h000A, 16'h000A, 4'b0000, 0);
      addv("out",     4'hD, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 0);
      addv("halt",    4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 0);
      addv("op7",     4'h7, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 0);
      addv("op14",    4'hE, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 0);
`ifdef ALU_SHIFT_EN
      addv("sra1",    4'hB, 16'h8001, 16'h0001, 16'hC000, 4'b1010, 1);
      addv("slr4",    4'h9, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 1);
      addv("sll0",    4'h8, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1);
      addv("srl1",    4'hA, 16'h8001, 16'h0001, 16'h4000, 4'b0010, 1);
      addv("sll1",    4'h8, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1);
      addv("sll_hi",  4'h8, 16'h4000, 16'hFFF1, 16'h8000, 4'b1000, 1);
      addv("sll15",   4'h8, 16'h0001, 16'h000F, 16'h8000, 4'b1000, 1);
      addv("sra_pos", 4'hB, 16'h4000, 16'h000E, 16'h0001, 4'b0000, 1);
`else
      addv("sll_off", 4'h8, 16'h1234, 16'h0001, 16'h0000, 4'b0100, 0);
      addv("slr_off", 4'h9, 16'h8001, 16'h0004, 16'h0000, 4'b0100, 0);
      addv("srl_off", 4'hA, 16'h8001, 16'h0001, 16'h0000, 4'b0100, 0);
      addv("sra_off", 4'hB, 16'h8001, 16'h0001, 16'h0000, 4'b0100, 0);
`endif

      foreach (vecs[i]) begin
         apply(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         #1;
         chk({vecs[i].nm, "_out"}, 32'(ALU_OUT), 32'(vecs[i].r));
         chk({vecs[i].nm, "_flag"}, 32'(FLAG_OUT), 32'(vecs[i].f));
         chk({vecs[i].nm, "_fw"}, 32'(FLAG_WRITE), 32'(vecs[i].fw));
      end

      chk("q_idle", 32'(FLAG_Q), 32'h0);

      apply(4'h0, 16'h7FFF, 16'h0001, 1'b1);
      apply(4'h6, 16'h1234, 16'h0000, 1'b0);
      #1;
      chk("q_add", 32'(FLAG_Q), 32'h9);
      apply(4'hF, 16'h0000, 16'h0000, 1'b1);
      #1;
      chk("q_mov_nolatch", 32'(FLAG_Q), 32'h9);
      apply(4'h1, 16'h0005, 16'h0005, 1'b0);
      #1;
      chk("q_halt_latch", 32'(FLAG_Q), 32'h9);

      #1;
      reset_n = 1'b0;
      #1;
      chk("q_async_rst", 32'(FLAG_Q), 32'h0);
      apply(4'h0, 16'h7FFF, 16'h0001, 1'b1);
      apply(4'h0, 16'h7FFF, 16'h0001, 1'b1);
      #1;
      chk("q_rst_hold", 32'(FLAG_Q), 32'h0);
      #4;
      reset_n = 1'b1;
      apply(4'h1, 16'h0003, 16'h0005, 1'b0);
      #1;
      chk("q_after_rst", 32'(FLAG_Q), 32'h9);
      apply(4'h0, 16'h0000, 16'h0000, 1'b0);
      #1;
      chk("q_hold", 32'(FLAG_Q), 32'h9);

      @(negedge clock);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
